// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS core blocks.
//   INSTR_W       instruction word width
//   OP_*          primary opcode values (instr[31:26])
//   instr_t       all instruction fields, decoded side by side
//   split_instr() splits a raw word into an instr_t
//   fetch_state_t fetch unit FSM states
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // The R, I and J formats overlap in the raw word. Each field is kept
    // separately so that decode can pick whichever fields it needs.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic instr_t split_instr(input logic [INSTR_W-1:0] w);
        instr_t f;
        f.opcode = w[31:26];
        f.rs     = w[25:21];
        f.rt     = w[20:16];
        f.rd     = w[15:11];
        f.shamt  = w[10:6];
        f.funct  = w[5:0];
        f.imm    = w[15:0];
        f.target = w[25:0];
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: groups the buses of the fetch unit.
//   imem_req_*  read request to instruction memory (valid/ready/addr)
//   imem_rsp_*  in-order read response (valid/data)
//   instr_*     buffered instruction sent to decode (valid/ready/data/pc)
//   redirect_*  branch/jump redirect coming from downstream
// master = fetch unit side; slave = memory, decode and redirect side.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    import mips_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [ADDR_W-1:0]   imem_req_addr;
    logic                imem_rsp_valid;
    logic [INSTR_W-1:0]  imem_rsp_data;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr_data;
    logic [ADDR_W-1:0]   instr_pc;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO whose head entry is held in a register.
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write an entry (ignored while full and not popping)
//   pop         drop the head entry (ignored while empty)
//   flush       empty the FIFO; takes priority over push
//   head        registered head entry (RST_VAL after reset)
//   count       number of stored entries, 0..DEPTH
module fetch_fifo #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // The head register is loaded with whatever entry becomes the front after
    // this cycle, so a word pushed into an empty FIFO is visible one cycle
    // later without a combinational path from din to head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= RST_VAL;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                count <= count + ONE;
            end else if (do_pop && !do_push) begin
                count <= count - ONE;
            end
            if (do_pop) begin
                if (count > ONE) begin
                    head <= mem[rd_next];
                end else if (do_push) begin
                    head <= din;
                end
            end else if ((count == '0) && do_push) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit. Owns the PC, issues in-order word
// reads to instruction memory and buffers returned words for decode.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         instr_fetch_if.master: imem request/response, instruction
//               output to decode, redirect input
// A redirect empties the buffer and turns the responses still in flight into
// stale ones; the FLUSH state discards them as they arrive.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam int               BUF_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W:0]   LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W-1:0]  out_after;
    logic [CNT_W:0]    in_use;
    logic [ADDR_W-1:0] rsp_pc;
    logic [BUF_W-1:0]  buf_head;
    logic              pop;
    logic              rsp;
    logic              accept;
    logic              push;

    assign pop = bus.instr_valid && bus.instr_ready;
    assign rsp = bus.imem_rsp_valid;

    // Words in flight plus words buffered, after this cycle's pop. Keeping it
    // below DEPTH on issue guarantees every response finds a free slot.
    assign in_use = {1'b0, outstanding} + {1'b0, buf_count} - {{CNT_W{1'b0}}, pop};

    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (in_use < LIMIT);
    assign bus.imem_req_addr  = pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    // No request is accepted in a redirect cycle, so only the response term
    // adjusts the in-flight count seen by the redirect.
    assign out_after = outstanding - {{(CNT_W-1){1'b0}}, rsp};
    assign push      = rsp && !bus.redirect_valid && (state == RUN);

    // PC shadow queue: one entry per accepted request, popped by every
    // response, stale or not. Its count is the outstanding-request counter.
    fetch_fifo #(
        .WIDTH   (ADDR_W),
        .DEPTH   (DEPTH),
        .RST_VAL (RESET_PC)
    ) u_pc_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (rsp),
        .flush (1'b0),
        .din   (pc),
        .head  (rsp_pc),
        .count (outstanding)
    );

    fetch_fifo #(
        .WIDTH   (BUF_W),
        .DEPTH   (DEPTH),
        .RST_VAL ({RESET_PC, {INSTR_W{1'b0}}})
    ) u_instr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   ({rsp_pc, bus.imem_rsp_data}),
        .head  (buf_head),
        .count (buf_count)
    );

    assign bus.instr_valid = (buf_count != '0);
    assign bus.instr_pc    = buf_head[BUF_W-1:INSTR_W];
    assign bus.instr_data  = buf_head[INSTR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            drop  <= '0;
            pc    <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc & ~ADDR_W'(3);
            drop  <= out_after;
            state <= (out_after != '0) ? FLUSH : RUN;
        end else begin
            if (accept) begin
                pc <= pc + ADDR_W'(4);
            end
            if (rsp && (state == FLUSH)) begin
                drop <= drop - ONE;
                if (drop == ONE) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. A small in-order memory
// model with programmable latency answers requests with data = ~address.
// A second instance with RESET_PC=0xFFFF_FFF8 and no responses shows the
// PC wrap through its first four requests.
module tb_instr_fetch;
    import mips_pkg::*;

    logic clk;
    logic rst_n;

    instr_fetch_if #(.ADDR_W(32)) bus ();
    instr_fetch_if #(.ADDR_W(32)) bus2 ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          n_acc  = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [31:0] acc2[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: bookkeeping on settled values at the falling edge, then the
    // memory model drives the next cycle's response just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq_addr.push_back(bus.imem_req_addr);
            mq_due.push_back(cyc + lat);
            n_acc++;
        end
        if (bus.imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (bus.instr_valid && bus.instr_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_data.push_back(bus.instr_data);
            got_cyc.push_back(cyc);
        end
        if (bus2.imem_req_valid && bus2.imem_req_ready) begin
            acc2.push_back(bus2.imem_req_addr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if ((mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(mq_addr[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        #1;
        chk("rst_req_valid",  bus.imem_req_valid, 0);
        chk("rst_req_addr",   bus.imem_req_addr, 32'h0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr_data", bus.instr_data, 32'h0);
        chk("rst_instr_pc",   bus.instr_pc, 32'h0);
        chk("rst_wrap_pc",    bus2.instr_pc, 32'hFFFF_FFF8);
        chk("rst_wrap_addr",  bus2.imem_req_addr, 32'hFFFF_FFF8);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_req_valid", bus.imem_req_valid, 0);
        mq_addr.delete();
        mq_due.delete();
        got_pc.delete();
        got_data.delete();
        got_cyc.delete();
        acc2.delete();
        cyc   = 0;
        n_acc = 0;
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr",  bus.imem_req_addr, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp [4];
        rst_n               = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.instr_ready     = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.instr_ready    = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        #2;

        // Reset and streaming with a latency-1 memory.
        lat = 1;
        do_reset();
        repeat (6) cycle();
        chk("stream_count", got_pc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc",   got_pc[i], 32'(4 * i));
            chk("stream_data", got_data[i], word_of(32'(4 * i)));
            chk("stream_cyc",  got_cyc[i], 2 + i);
        end

        // Wrap instance: four credits, no responses.
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        chk("wrap_count", acc2.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", acc2[i], wrap_exp[i]);
        end

        // Backpressure for 10 cycles.
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("bp_credit", ((n_acc - got_pc.size()) <= 4), 1);
            chk("bp_hold_pc",   bus.instr_pc, 32'h10);
            chk("bp_hold_data", bus.instr_data, word_of(32'h10));
        end
        chk("bp_req_dropped", bus.imem_req_valid, 0);
        chk("bp_instr_valid", bus.instr_valid, 1);
        bus.instr_ready = 1'b1;
        repeat (15) cycle();
        chk("bp_total", got_pc.size(), 19);
        for (int i = 0; i < got_pc.size(); i++) begin
            chk("bp_seq_pc",   got_pc[i], 32'(4 * i));
            chk("bp_seq_data", got_data[i], word_of(32'(4 * i)));
        end

        // Redirect with two requests in flight, latency-3 memory (mid-run reset).
        lat = 3;
        do_reset();
        while (cyc < 2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        #1;
        chk("rd_no_req", bus.imem_req_valid, 0);
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd_drop",      dut.drop, 2);
        chk("rd_state",     dut.state, 1);
        chk("rd_req_valid", bus.imem_req_valid, 1);
        chk("rd_req_addr",  bus.imem_req_addr, 32'h100);
        while (cyc < 12) cycle();
        chk("rd_count", got_pc.size(), 5);
        for (int i = 0; i < got_pc.size(); i++) begin
            chk("rd_pc",   got_pc[i], 32'h100 + 32'(4 * i));
            chk("rd_data", got_data[i], word_of(32'h100 + 32'(4 * i)));
        end
        chk("rd_first_cyc", got_cyc[0], 7);

        // Redirect together with a response and a pop, latency-2 memory.
        lat = 2;
        do_reset();
        while (cyc < 4) cycle();
        chk("sim_pre_valid", bus.instr_valid, 1);
        chk("sim_pre_pc",    bus.instr_pc, 32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        #1;
        chk("sim_no_req", bus.imem_req_valid, 0);
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("sim_drop",        dut.drop, 1);
        chk("sim_state",       dut.state, 1);
        chk("sim_instr_valid", bus.instr_valid, 0);
        chk("sim_req_addr",    bus.imem_req_addr, 32'h300);
        while (cyc < 10) cycle();
        chk("sim_count", got_pc.size(), 4);
        if (got_pc.size() == 4) begin
            chk("sim_pc0", got_pc[0], 32'h0);
            chk("sim_pc1", got_pc[1], 32'h4);
            chk("sim_pc2", got_pc[2], 32'h300);
            chk("sim_pc3", got_pc[3], 32'h304);
            chk("sim_data2", got_data[2], word_of(32'h300));
            chk("sim_cyc2", got_cyc[2], 8);
        end

        // Second redirect while still flushing, latency-3 memory.
        lat = 3;
        do_reset();
        while (cyc < 2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("fl_req_in_flush", bus.imem_req_valid, 1);
        chk("fl_req_addr",     bus.imem_req_addr, 32'h100);
        cycle();
        chk("fl_state_mid", dut.state, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("fl_drop",  dut.drop, 1);
        chk("fl_state", dut.state, 1);
        while (cyc < 14) cycle();
        chk("fl_count", got_pc.size(), 5);
        for (int i = 0; i < got_pc.size(); i++) begin
            chk("fl_pc",   got_pc[i], 32'h200 + 32'(4 * i));
            chk("fl_data", got_data[i], word_of(32'h200 + 32'(4 * i)));
        end
        chk("fl_state_end", dut.state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
